fios_res_collector: RTL and testbench



---
 rtl/fios_res_collector_if.sv | 18 +
 rtl/fios_res_collector.sv | 106 ++++++++++
 tb/tb_fios_res_collector.sv | 134 +++++++++++++
 3 files changed

// File: rtl/fios_res_collector_if.sv
// Result-path bundle for the FIOS collector: word-serial input stream from the
// last PE and the reduced-product valid/ready output.
interface fios_res_collector_if #(
  parameter int s      = 8,
  parameter int WORD_W = 17
);
  logic                  res_valid_i;
  logic [WORD_W-1:0]     res_i;
  logic [s*WORD_W-1:0]   res_o;
  logic                  res_valid_o;
  logic                  res_ready_i;

  // master: multiplier + consumer side; slave: the collector
  modport master (output res_valid_i, res_i, res_ready_i,
                  input  res_o, res_valid_o);
  modport slave  (input  res_valid_i, res_i, res_ready_i,
                  output res_o, res_valid_o);
endinterface

// File: rtl/fios_res_collector.sv
// Reassembles the FIOS result stream (LSW first), applies the conditional
// final subtraction T - p one word per cycle, and holds T mod p for handshake.
module fios_res_collector #(
  parameter int s      = 8,
  parameter int WORD_W = 17
) (
  input  logic                  clock_i,
  input  logic                  reset_i,
  fios_res_collector_if.slave   bus,
  input  logic [s*WORD_W-1:0]   p_i,
  output logic                  busy_o,
  output logic                  overflow_err_o
);
  localparam int CW = (s > 1) ? $clog2(s) : 1;

  typedef enum logic [1:0] {COLLECT, SUB, OUT} state_t;
  typedef logic [s-1:0][WORD_W-1:0] words_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, j_q;
  logic            borrow_q;
  words_t          t_buf_q, d_buf_q, res_q, res_sel, p_w;
  logic            res_valid_q, ovf_q;
  logic [WORD_W:0] diff;
  logic            last_word, last_sub, handshake;

  assign p_w       = p_i;
  assign last_word = bus.res_valid_i && (cnt_q == CW'(s-1));
  assign last_sub  = (j_q == CW'(s-1));
  assign handshake = res_valid_q && bus.res_ready_i;

  // bit WORD_W of the zero-extended difference is the outgoing borrow
  assign diff = {1'b0, t_buf_q[j_q]} - {1'b0, p_w[j_q]} - {{WORD_W{1'b0}}, borrow_q};

  // top word comes straight from this cycle's subtraction; borrow out means T < p
  always_comb begin
    res_sel        = d_buf_q;
    res_sel[s-1]   = diff[WORD_W-1:0];
    if (diff[WORD_W]) res_sel = t_buf_q;
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) state_q <= COLLECT;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      COLLECT: if (last_word) state_d = SUB;
      SUB:     if (last_sub)  state_d = OUT;
      OUT:     if (handshake) state_d = COLLECT;
      default:                state_d = COLLECT;
    endcase
  end

  always_comb begin
    busy_o          = (state_q != COLLECT) || (cnt_q != '0);
    overflow_err_o  = ovf_q;
    bus.res_o       = res_q;
    bus.res_valid_o = res_valid_q;
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      cnt_q       <= '0;
      j_q         <= '0;
      borrow_q    <= 1'b0;
      t_buf_q     <= '0;
      d_buf_q     <= '0;
      res_q       <= '0;
      res_valid_q <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      case (state_q)
        COLLECT: begin
          if (bus.res_valid_i) begin
            t_buf_q[cnt_q] <= bus.res_i;
            if (last_word) begin
              cnt_q    <= '0;
              j_q      <= '0;
              borrow_q <= 1'b0;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
        SUB: begin
          d_buf_q[j_q] <= diff[WORD_W-1:0];
          borrow_q     <= diff[WORD_W];
          if (last_sub) begin
            j_q         <= '0;
            res_q       <= res_sel;
            res_valid_q <= 1'b1;
          end else begin
            j_q <= j_q + 1'b1;
          end
        end
        OUT: if (handshake) res_valid_q <= 1'b0;
        default: ;
      endcase
      // a word landing outside COLLECT is dropped; the flag is sticky
      if ((state_q != COLLECT) && bus.res_valid_i) ovf_q <= 1'b1;
    end
  end
endmodule

// File: tb/tb_fios_res_collector.sv
// Directed bench for fios_res_collector with s=2 and hand-computed results.
module tb_fios_res_collector;
  localparam int S = 2;
  localparam int W = 17;

  logic             clk = 1'b0;
  logic             rst;
  logic [S*W-1:0]   p;
  logic             busy, ovf;
  int               n_tests = 0;
  int               n_fail  = 0;

  fios_res_collector_if #(.s(S), .WORD_W(W)) bus ();

  fios_res_collector #(.s(S), .WORD_W(W)) dut (
    .clock_i        (clk),
    .reset_i        (rst),
    .bus            (bus.slave),
    .p_i            (p),
    .busy_o         (busy),
    .overflow_err_o (ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // word is captured at the posedge between the two negedges
  task automatic send(input logic [W-1:0] w);
    @(negedge clk);
    bus.res_valid_i = 1'b1;
    bus.res_i       = w;
    @(negedge clk);
    bus.res_valid_i = 1'b0;
    bus.res_i       = '0;
  endtask

  task automatic collect(input string tag, input logic [S*W-1:0] pm,
                         input logic [W-1:0] w0, input logic [W-1:0] w1,
                         input logic [S*W-1:0] exp, input int gap);
    p = pm;
    send(w0);
    check({tag, ".busy_mid"}, 64'(busy), 64'd1);
    repeat (gap) @(negedge clk);
    send(w1);
    @(negedge clk);
    check({tag, ".vld_e1"}, 64'(bus.res_valid_o), 64'd0);
    @(negedge clk);
    check({tag, ".vld_e2"}, 64'(bus.res_valid_o), 64'd1);
    check({tag, ".res"}, 64'(bus.res_o), 64'(exp));
  endtask

  task automatic accept(input string tag);
    bus.res_ready_i = 1'b1;
    @(negedge clk);
    bus.res_ready_i = 1'b0;
    check({tag, ".vld_done"}, 64'(bus.res_valid_o), 64'd0);
    check({tag, ".busy_done"}, 64'(busy), 64'd0);
  endtask

  initial begin
    rst             = 1'b1;
    p               = '0;
    bus.res_valid_i = 1'b0;
    bus.res_i       = '0;
    bus.res_ready_i = 1'b0;
    repeat (2) @(negedge clk);
    check("rst.vld",  64'(bus.res_valid_o), 64'd0);
    check("rst.res",  64'(bus.res_o), 64'd0);
    check("rst.busy", 64'(busy), 64'd0);
    check("rst.ovf",  64'(ovf), 64'd0);
    rst = 1'b0;

    // T=131080, p=131075 -> 5
    collect("ge", {17'h00001, 17'h00003}, 17'h8, 17'h1, {17'h0, 17'h5}, 0);
    accept("ge");
    // T < p -> T unchanged
    collect("lt", {17'h00001, 17'h00003}, 17'h7, 17'h0, {17'h0, 17'h7}, 0);
    accept("lt");
    // T == p -> 0
    collect("eq", {17'h00001, 17'h00003}, 17'h3, 17'h1, 34'h0, 0);
    accept("eq");
    // borrow ripples out of word 0
    collect("brw", {17'h00001, 17'h1FFFF}, 17'h0, 17'h2, {17'h0, 17'h1}, 0);
    accept("brw");
    // gap between words; 0x3FFFF - 0x20003 = 0x1FFFC
    collect("gap", {17'h00001, 17'h00003}, 17'h1FFFF, 17'h1, {17'h0, 17'h1FFFC}, 3);
    accept("gap");
    check("pre_bp.ovf", 64'(ovf), 64'd0);

    // backpressure with a stray word arriving in OUT
    collect("bp", {17'h00001, 17'h00003}, 17'h8, 17'h1, {17'h0, 17'h5}, 0);
    bus.res_valid_i = 1'b1;
    bus.res_i       = 17'h1ABCD;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      bus.res_valid_i = 1'b0;
      check("bp.vld_hold", 64'(bus.res_valid_o), 64'd1);
      check("bp.res_hold", 64'(bus.res_o), 64'({17'h0, 17'h5}));
      check("bp.ovf", 64'(ovf), 64'd1);
    end
    accept("bp");
    check("bp.res_kept", 64'(bus.res_o), 64'({17'h0, 17'h5}));
    check("bp.ovf_sticky", 64'(ovf), 64'd1);

    // next result after the drop must be clean
    collect("post", {17'h00001, 17'h00003}, 17'h7, 17'h0, {17'h0, 17'h7}, 0);
    accept("post");
    check("post.ovf_sticky", 64'(ovf), 64'd1);

    // asynchronous reset after one word of two
    p = {17'h00001, 17'h00003};
    send(17'h9);
    check("mid.busy", 64'(busy), 64'd1);
    #2 rst = 1'b1;
    #1;
    check("mid.busy_rst", 64'(busy), 64'd0);
    check("mid.ovf_rst",  64'(ovf), 64'd0);
    check("mid.res_rst",  64'(bus.res_o), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    collect("fresh", {17'h00001, 17'h00003}, 17'h8, 17'h1, {17'h0, 17'h5}, 0);
    accept("fresh");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
